// File: rtl/bus_responder.sv
// Bus responder: receive FIFO between the bus arbiter and a consumer, tagging each word with its source core.
// Optional build macro BUS_RESP_PARITY_EN drops words with bad even parity and counts them.
//
// Occupancy states:
//   state     | meaning
//   S_EMPTY   | no words held, out_valid low
//   S_PARTIAL | 1 .. DEPTH-1 words held
//   S_FULL    | DEPTH words held, bus_ready low
module bus_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        bus_data,
  input  logic                     bus_valid,
  input  logic                     bus_src,
  input  logic                     bus_parity,
  output logic                     bus_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               parity_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } occ_e;

  occ_e               state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]   src_q, src_d;

  logic push_req;
  logic push_store;
  logic pop;
  logic par_bad;

  assign bus_ready  = (state_q != S_FULL);
  assign out_valid  = (state_q != S_EMPTY);
  assign out_data   = mem_q[rd_ptr_q];
  assign out_src    = src_q[rd_ptr_q];
  assign fifo_count = count_q;

  assign push_req   = bus_valid & bus_ready;
  assign pop        = out_valid & out_ready;
  assign push_store = push_req & ~par_bad;

`ifdef BUS_RESP_PARITY_EN
  logic [7:0] perr_q, perr_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = (^bus_data) ^ bus_parity;

  always_comb begin
    perr_d = perr_q;
    if (push_req && par_bad && (perr_q != 8'hFF)) begin
      perr_d = perr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 8'd0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err_cnt = perr_q;
`else
  logic unused_parity;

  assign unused_parity  = bus_parity;
  assign par_bad        = 1'b0;
  assign parity_err_cnt = 8'd0;
`endif

  always_comb begin
    mem_d    = mem_q;
    src_d    = src_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_store) begin
      mem_d[wr_ptr_q] = bus_data;
      src_d[wr_ptr_q] = bus_src;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_store, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // A simultaneous push and pop never changes state; only single-sided moves step it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (push_store) begin
          state_d = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (push_store && !pop && (count_q == DEPTH_C - ONE_C)) begin
          state_d = S_FULL;
        end else if (pop && !push_store && (count_q == ONE_C)) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_PARTIAL;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      src_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      src_q    <= src_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bus_data, input, DATA_W bits: word driven by the bus arbiter.
REQ-006 SHALL have port bus_valid, input, 1 bit: bus_data is valid this cycle.
REQ-007 SHALL have port bus_src, input, 1 bit: originating core; 0 means core A, 1 means core B.
REQ-008 SHALL have port bus_parity, input, 1 bit: even-parity bit over bus_data; it is ignored unless REQ-026 applies.
REQ-009 SHALL have port bus_ready, output, 1 bit: the responder accepts a word this cycle.
REQ-010 SHALL have port out_data, output, DATA_W bits: word at the FIFO head.
REQ-011 SHALL have port out_src, output, 1 bit: bus_src value stored with the head word.
REQ-012 SHALL have port out_valid, output, 1 bit: the head word is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the head word.
REQ-014 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port parity_err_cnt, output, 8 bits: count of discarded words.

Function
REQ-016 A push SHALL occur on a rising edge where bus_valid=1 and bus_ready=1; the word is stored together with bus_src.
REQ-017 bus_ready SHALL be combinationally 1 when fifo_count is less than DEPTH, and 0 otherwise.
- There is no pass-through when the FIFO is full, even if out_ready=1.
REQ-018 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-019 out_valid SHALL be 1 exactly when fifo_count is not 0.
- out_data and out_src come from registered storage; they are not combinational from bus_data.
REQ-020 Latency SHALL be one cycle: a word pushed at edge N is visible on out_data with out_valid=1 after edge N.
REQ-021 Push and pop on the same edge SHALL leave fifo_count unchanged and keep FIFO order intact.
- This holds when the FIFO is full: no push is possible then, so only the pop occurs.
- This holds when the FIFO is empty: no pop is possible then, so only the push occurs.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; ordering SHALL be strictly first-in first-out.
REQ-023 Occupancy state SHALL be EMPTY (count 0), PARTIAL, or FULL (count DEPTH).
- Each push moves the state one step toward FULL.
- Each pop moves the state one step toward EMPTY.
- A simultaneous push and pop holds the state.
REQ-024 out_data and out_src SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-025 rst_n=0 SHALL immediately drive the following, regardless of any transfer in progress:
- fifo_count=0, out_valid=0, bus_ready=1 (one cycle after release as well), parity_err_cnt=0;
- out_data=0, out_src=0, and both pointers=0.
- A word whose push edge coincides with reset assertion is lost.

Configuration
REQ-026 With macro BUS_RESP_PARITY_EN defined:
- A push-qualified word whose XOR of bus_data and bus_parity is 1 SHALL be discarded and not stored.
- bus_ready is still 1 for that word, so the sender sees a completed transfer.
- parity_err_cnt increments by 1 per discarded word and saturates at 255.
REQ-027 Without BUS_RESP_PARITY_EN:
- bus_parity SHALL be ignored and every push is stored.
- parity_err_cnt SHALL be constant 0.
- The port list is identical in both builds.

Verification
REQ-028 Basic transfer: after reset, push 0xDEADBEEF with bus_src=1 while out_ready=0 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_src=1, fifo_count=1.
REQ-029 Full: push 0x1, 0x2, 0x3, 0x4 with out_ready=0 -> fifo_count=4 and bus_ready=0.
- A fifth bus_valid with 0x5 is not accepted.
- Then pop 4 times -> outputs are 0x1, 0x2, 0x3, 0x4 in order and out_valid=0.
REQ-030 Simultaneous: with fifo_count=2, hold bus_valid=1 and out_ready=1 for 6 cycles with incrementing data -> fifo_count stays 2 and order is preserved across pointer wrap.
REQ-031 Reset mid-operation: with fifo_count=3, assert rst_n=0 asynchronously between edges -> fifo_count=0, out_valid=0, out_data=0 without waiting for a clock edge.
REQ-032 Parity (BUS_RESP_PARITY_EN defined): push 0x00000001 with bus_parity=0 -> word discarded, parity_err_cnt=1, fifo_count=0.
- Push 0x00000001 with bus_parity=1 -> word stored.
- 300 bad words -> parity_err_cnt=255.
REQ-033 Parity (BUS_RESP_PARITY_EN undefined): repeat REQ-032 stimulus -> both words stored and parity_err_cnt=0.
